// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 asynchronous UART receiver, LSB first, idle-high line.
//               Each bit is sampled at mid-period. A correctly framed byte is
//               presented on data with a one-cycle data_valid strobe. A stop
//               bit sampled low raises a one-cycle frame_err strobe, discards
//               the byte, and parks the receiver until the line returns high.
// Ports       : clk        - system clock, all logic on posedge
//               rst        - synchronous reset, active-high
//               rx         - asynchronous serial line, idle high
//               data       - last correctly framed byte
//               data_valid - one-cycle strobe, data updated this cycle
//               frame_err  - one-cycle strobe, stop bit sampled low
//               busy       - high in any state other than IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 5626
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] c_half_m1  = CW'(HALF - 1);
    localparam logic [CW-1:0] c_bit_last = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // Two-stage synchronizer; only r_rx_s is used by the receiver.
    logic          r_sync1;
    logic          r_rx_s;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_sh;
    logic [7:0]    r_data;
    logic          r_data_valid;
    logic          r_frame_err;

    state_t        w_state_nx;
    logic [CW-1:0] w_cnt_nx;
    logic [2:0]    w_bit_idx_nx;
    logic [7:0]    w_sh_nx;
    logic [7:0]    w_data_nx;
    logic          w_data_valid_nx;
    logic          w_frame_err_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1      <= 1'b1;
            r_rx_s       <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_sh         <= 8'h00;
            r_data       <= 8'h00;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync1      <= rx;
            r_rx_s       <= r_sync1;
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_bit_idx    <= w_bit_idx_nx;
            r_sh         <= w_sh_nx;
            r_data       <= w_data_nx;
            r_data_valid <= w_data_valid_nx;
            r_frame_err  <= w_frame_err_nx;
        end
    end

    // The counter only runs in START/DATA/STOP; every state transition
    // restarts it so each phase measures from its own entry point.
    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt + c_cnt_one;
        w_bit_idx_nx    = r_bit_idx;
        w_sh_nx         = r_sh;
        w_data_nx       = r_data;
        w_data_valid_nx = 1'b0;
        w_frame_err_nx  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (!r_rx_s) begin
                    w_state_nx = S_START;
                end
            end

            S_START: begin
                // Half a bit in: a line that has gone high again was a glitch.
                if (r_cnt == c_half_m1) begin
                    w_cnt_nx = '0;
                    if (!r_rx_s) begin
                        w_state_nx   = S_DATA;
                        w_bit_idx_nx = 3'd0;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nx          = '0;
                    w_sh_nx[r_bit_idx] = r_rx_s;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                    end
                end
            end

            S_STOP: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nx = '0;
                    if (r_rx_s) begin
                        w_data_nx       = r_sh;
                        w_data_valid_nx = 1'b1;
                        w_state_nx      = S_IDLE;
                    end else begin
                        w_frame_err_nx = 1'b1;
                        w_state_nx     = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                // A line held low must not look like a stream of start bits.
                w_cnt_nx = '0;
                if (r_rx_s) begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_cnt_nx   = '0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (CLKS_PER_BIT = 16). Every
//               driven frame pushes its predicted outcome to a scoreboard;
//               the monitor pops and compares on each strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         n_dv    = 0;
    int         t_start = 0;
    int         t_strobe = 0;
    logic [7:0] exp_data = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc = number of posedges seen so far
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line level seen s clocks after the start edge when frame bits last p clocks.
    function automatic logic line_at(input logic [7:0] d, input int p, input logic stop_v, input int s);
        int idx;
        idx = s / p;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        return stop_v;
    endfunction

    // The receiver looks at the line HALF + j*CPB clocks after the start edge
    // (j = 0 start, 1..8 data, 9 stop). At off-nominal bit rates the later
    // sampling points may land in a neighbouring bit, so predict from them.
    function automatic void predict(input logic [7:0] d, input int p, input logic stop_v);
        exp_t       e;
        logic [7:0] got;
        if (line_at(d, p, stop_v, HALF) != 1'b0) return;
        for (int j = 1; j <= 8; j++) got[j-1] = line_at(d, p, stop_v, HALF + j*CPB);
        if (line_at(d, p, stop_v, HALF + 9*CPB)) begin
            e.err    = 1'b0;
            e.data   = got;
            exp_data = got;
        end else begin
            e.err  = 1'b1;
            e.data = exp_data;
        end
        sb.push_back(e);
    endfunction

    task automatic send_frame(input logic [7:0] d, input int p, input logic stop_v);
        logic [9:0] bits;
        bits = {stop_v, d, 1'b0};
        predict(d, p, stop_v);
        @(posedge clk);
        #1;
        t_start = cyc;
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            repeat (p) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && (data_valid || frame_err)) begin
            check("strobe_exclusive", {31'd0, data_valid & frame_err}, 0);
            check("strobe_expected", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("strobe_kind", {30'd0, data_valid, frame_err}, e.err ? 2'b01 : 2'b10);
                check("strobe_data", {24'd0, data}, {24'd0, e.data});
            end
            if (data_valid) begin
                n_dv++;
                t_strobe = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int dv0;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data", {24'd0, data}, 0);
        check("rst_dv", {31'd0, data_valid}, 0);
        check("rst_fe", {31'd0, frame_err}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        idle(8);

        // 1: single frame, strobe latency
        send_frame(8'hA5, CPB, 1'b1);
        drain();
        check("lat_A5", t_strobe, t_start + 1 + 2 + HALF + 9*CPB);
        check("hold_A5", {24'd0, data}, 32'hA5);
        idle(20);

        // 2: back-to-back frames
        dv0 = n_dv;
        send_frame(8'h00, CPB, 1'b1);
        send_frame(8'hFF, CPB, 1'b1);
        drain();
        check("b2b_count", n_dv - dv0, 2);
        check("hold_FF", {24'd0, data}, 32'hFF);
        idle(20);

        // 3: short glitch rejected
        @(posedge clk);
        #1;
        c  = cyc;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        wait_cyc(c + 1 + 2);
        check("glitch_busy_rise", {31'd0, busy}, 1);
        wait_cyc(c + 1 + 9);
        check("glitch_busy_late", {31'd0, busy}, 1);
        wait_cyc(c + 1 + 2 + HALF);
        check("glitch_busy_fall", {31'd0, busy}, 0);
        idle(40);
        check("glitch_data", {24'd0, data}, 32'hFF);

        // 4: frame error, break, recovery
        send_frame(8'h3C, CPB, 1'b0);
        repeat (64) @(posedge clk);
        #1;
        check("break_busy", {31'd0, busy}, 1);
        check("break_data", {24'd0, data}, 32'hFF);
        check("break_sb", sb.size(), 0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("break_exit", {31'd0, busy}, 0);
        idle(10);
        send_frame(8'h5A, CPB, 1'b1);
        drain();
        idle(20);

        // 5: reset in the middle of data bit 4; the transmitter abandons the frame
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int b = 0; b < 4; b++) begin
            rx = b == 0;
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_data = 8'h00;
        check("mrst_data", {24'd0, data}, 0);
        check("mrst_dv", {31'd0, data_valid}, 0);
        check("mrst_fe", {31'd0, frame_err}, 0);
        check("mrst_busy", {31'd0, busy}, 0);
        idle(3 * CPB);
        check("mrst_hold", {24'd0, data}, 0);
        send_frame(8'h42, CPB, 1'b1);
        drain();
        idle(20);

        // 6: off-nominal bit rates
        send_frame(8'h55, 15, 1'b1);
        drain();
        idle(40);
        send_frame(8'h55, 17, 1'b1);
        drain();
        idle(40);
        check("end_busy", {31'd0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
